bidir_io_cfg_ctrl: RTL and testbench
====================================

BIDIR_IO_CFG_CTRL -- requirements
Module: bidir_io_cfg_ctrl

Interface
REQ-001 SHALL have parameter IOWidth, default 36: number of I/O pins configured.
REQ-002 SHALL have parameter PortNumWidth, default 8: width of each per-pin port-select field.
REQ-003 SHALL have parameter GuardCycles, default 2, legal range 1..15: output-disable cycles before and after a configuration switch.
REQ-004 SHALL have parameter AddrWidth, default 6, with 2^AddrWidth >= IOWidth: pin index width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port wr_en, input, 1 bit: shadow write strobe.
REQ-008 SHALL have port wr_addr, input, AddrWidth bits: pin index of the write.
REQ-009 SHALL have port wr_data, input, PortNumWidth+2 bits: [PortNumWidth-1:0] port select, [PortNumWidth] out_ena, [PortNumWidth+1] od.
REQ-010 SHALL have port wr_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-011 SHALL have port rd_en, input, 1 bit: shadow readback strobe.
REQ-012 SHALL have port rd_addr, input, AddrWidth bits: readback pin index.
REQ-013 SHALL have port rd_data, output, PortNumWidth+2 bits: registered shadow readback, same field layout as wr_data.
REQ-014 SHALL have port commit_req, input, 1 bit: request to apply the shadow configuration.
REQ-015 SHALL have port busy, output, 1 bit: high while a commit sequence runs.
REQ-016 SHALL have port commit_done, output, 1 bit: one-cycle pulse when a commit completes.
REQ-017 SHALL have port portselnum, output, unpacked array of IOWidth entries of PortNumWidth bits each: active per-pin mux select.
REQ-018 SHALL have port out_ena, output, IOWidth bits: active per-pin output enable, after guard masking.
REQ-019 SHALL have port od, output, IOWidth bits: active per-pin open-drain select.

Function
REQ-020 SHALL hold two register banks, shadow and active, each with per-pin {portsel, out_ena, od}.
REQ-021 SHALL write wr_data into shadow[wr_addr] on a cycle with wr_en=1, busy=0 and wr_addr<IOWidth.
REQ-022 SHALL ignore a write with wr_addr>=IOWidth or busy=1, with no state change, and SHALL pulse wr_err in the next cycle.
REQ-023 SHALL load rd_data with shadow[rd_addr] one cycle after rd_en=1; rd_addr>=IOWidth SHALL return 0; without rd_en, rd_data SHALL hold its value.
REQ-024 SHALL implement the state machine IDLE -> GUARD -> APPLY -> SETTLE -> IDLE.
REQ-025 SHALL leave IDLE only when commit_req=1 is sampled in IDLE; commit_req while busy SHALL be ignored, with no queuing.
REQ-026 SHALL, on commit accept at cycle T, register changed_mask[i] = (shadow[i] != active[i]), with the mask visible from T+1.
- A write accepted in the same cycle T SHALL be excluded from changed_mask but SHALL be applied at APPLY.
- Writes are blocked from T+1, so no later write can reach active.
REQ-027 SHALL remain in GUARD for exactly GuardCycles cycles (T+1..T+G), then APPLY for one cycle (T+G+1), copying all of shadow to active, visible at T+G+2.
REQ-028 SHALL remain in SETTLE for GuardCycles cycles (T+G+2..T+2G+1), then return to IDLE at T+2G+2 with commit_done=1 in that cycle only.
REQ-029 SHALL drive busy=1 exactly in cycles T+1..T+2G+1.
REQ-030 SHALL drive out_ena = active_out_ena & ~force_mask combinationally, where force_mask = changed_mask during GUARD/APPLY/SETTLE and 0 in IDLE.
REQ-031 SHALL drive portselnum and od directly from the active bank; unchanged pins SHALL see no glitch or disable during a commit.
REQ-032 SHALL run the full sequence and timing when a commit has zero changed pins (mask all-zero).

Reset
REQ-033 SHALL, on reset assertion at any time including mid-commit, immediately set state=IDLE and changed_mask=0.
REQ-034 SHALL, on reset, set both banks to portsel[i]=i, out_ena=0, od=0, so outputs are portselnum[i]=i, out_ena=0, od=0.
REQ-035 SHALL, on reset, set busy=0, commit_done=0, wr_err=0 and rd_data=0.

Verification
REQ-036 SHALL cover: after reset, read pins 0/5/35 -> rd_data={od=0,ena=0,sel=0/5/35}; portselnum[35]=35, out_ena=0.
REQ-037 SHALL cover: G=2, write pin 3 {sel=7,ena=1,od=0}, commit at T -> busy T+1..T+5, active visible T+4, commit_done at T+6, out_ena[3]=0 through T+5 and 1 at T+6.
REQ-038 SHALL cover: after pin 4 is active with ena=1, commit changing only pin 3 -> out_ena[4] stays 1 every cycle and portselnum[4] is constant.
REQ-039 SHALL cover: write during busy and write to addr 40 -> wr_err pulse the next cycle, shadow unchanged on readback.
REQ-040 SHALL cover: commit_req held high 10 cycles -> exactly one commit sequence, then a second commit only if still high when back in IDLE.
REQ-041 SHALL cover: reset asserted at T+3 of a commit -> same-cycle IDLE, busy=0, out_ena=0, portselnum[i]=i, no commit_done.

Source files
------------

// File: rtl/bidir_io_cfg_ctrl.sv
// Per-pin I/O mux configuration with a shadow/active bank pair and a guarded commit:
// pins whose configuration changes are output-disabled around the bank switch.
module bidir_io_cfg_ctrl #(
  parameter int IOWidth      = 36,
  parameter int PortNumWidth = 8,
  parameter int GuardCycles  = 2,
  parameter int AddrWidth    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [AddrWidth-1:0]    wr_addr,
  input  logic [PortNumWidth+1:0] wr_data,
  output logic                    wr_err,
  input  logic                    rd_en,
  input  logic [AddrWidth-1:0]    rd_addr,
  output logic [PortNumWidth+1:0] rd_data,
  input  logic                    commit_req,
  output logic                    busy,
  output logic                    commit_done,
  output logic [PortNumWidth-1:0] portselnum [IOWidth],
  output logic [IOWidth-1:0]      out_ena,
  output logic [IOWidth-1:0]      od
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_APPLY  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [3:0]         LP_GLAST = 4'(GuardCycles - 1);
  localparam logic [AddrWidth:0] LP_IOW   = (AddrWidth + 1)'(IOWidth);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_cnt;
  logic [IOWidth-1:0]      r_chg;
  logic [PortNumWidth-1:0] r_sh_sel  [IOWidth];
  logic [IOWidth-1:0]      r_sh_ena;
  logic [IOWidth-1:0]      r_sh_od;
  logic [PortNumWidth-1:0] r_act_sel [IOWidth];
  logic [IOWidth-1:0]      r_act_ena;
  logic [IOWidth-1:0]      r_act_od;
  logic                    r_wr_err;
  logic                    r_commit_done;
  logic [PortNumWidth+1:0] r_rd_data;

  logic                    w_busy;
  logic                    w_accept;
  logic                    w_apply;
  logic                    w_last;
  logic                    w_wr_ok;
  logic [IOWidth-1:0]      w_force;

  assign w_wr_ok = wr_en && !w_busy && ({1'b0, wr_addr} < LP_IOW);
  assign w_force = w_busy ? r_chg : {IOWidth{1'b0}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = commit_req ? ST_GUARD : ST_IDLE;
      ST_GUARD:  w_next_state = (r_cnt == LP_GLAST) ? ST_APPLY : ST_GUARD;
      ST_APPLY:  w_next_state = ST_SETTLE;
      ST_SETTLE: w_next_state = (r_cnt == LP_GLAST) ? ST_IDLE : ST_SETTLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = 1'b1;
    w_accept = 1'b0;
    w_apply  = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy   = 1'b0;
        w_accept = commit_req;
      end
      ST_GUARD:  w_busy = 1'b1;
      ST_APPLY:  w_apply = 1'b1;
      ST_SETTLE: w_last = (r_cnt == LP_GLAST);
      default:   w_busy = 1'b0;
    endcase
  end

  // Dwell counter restarts on every state change so GUARD and SETTLE each last GuardCycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if ((r_state != w_next_state) || !w_busy) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Mask is taken from the shadow as it stood before any write landing in the accept cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chg <= {IOWidth{1'b0}};
    end else if (w_accept) begin
      for (int i = 0; i < IOWidth; i++) begin
        r_chg[i] <= (r_sh_sel[i] != r_act_sel[i]) || (r_sh_ena[i] != r_act_ena[i]) ||
                    (r_sh_od[i] != r_act_od[i]);
      end
    end else begin
      r_chg <= r_chg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IOWidth; i++) begin
        r_sh_sel[i] <= PortNumWidth'(i);
      end
      r_sh_ena <= {IOWidth{1'b0}};
      r_sh_od  <= {IOWidth{1'b0}};
    end else if (w_wr_ok) begin
      r_sh_sel[wr_addr] <= wr_data[PortNumWidth-1:0];
      r_sh_ena[wr_addr] <= wr_data[PortNumWidth];
      r_sh_od[wr_addr]  <= wr_data[PortNumWidth+1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IOWidth; i++) begin
        r_act_sel[i] <= PortNumWidth'(i);
      end
      r_act_ena <= {IOWidth{1'b0}};
      r_act_od  <= {IOWidth{1'b0}};
    end else if (w_apply) begin
      r_act_sel <= r_sh_sel;
      r_act_ena <= r_sh_ena;
      r_act_od  <= r_sh_od;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_err      <= 1'b0;
      r_commit_done <= 1'b0;
      r_rd_data     <= {(PortNumWidth + 2){1'b0}};
    end else begin
      r_wr_err      <= wr_en && !w_wr_ok;
      r_commit_done <= w_last;
      if (rd_en) begin
        if ({1'b0, rd_addr} < LP_IOW) begin
          r_rd_data <= {r_sh_od[rd_addr], r_sh_ena[rd_addr], r_sh_sel[rd_addr]};
        end else begin
          r_rd_data <= {(PortNumWidth + 2){1'b0}};
        end
      end
    end
  end

  assign busy        = w_busy;
  assign commit_done = r_commit_done;
  assign wr_err      = r_wr_err;
  assign rd_data     = r_rd_data;
  assign portselnum  = r_act_sel;
  assign out_ena     = r_act_ena & ~w_force;
  assign od          = r_act_od;

endmodule

// File: tb/tb_bidir_io_cfg_ctrl.sv
// Bench for bidir_io_cfg_ctrl: a timestamp-based model of the commit sequence checked
// every cycle, plus directed scenarios with literal expectations.
module tb_bidir_io_cfg_ctrl;
  localparam int IOW = 36;
  localparam int PW  = 8;
  localparam int G   = 2;
  localparam int AW  = 6;
  localparam int DW  = PW + 2;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          wr_en      = 1'b0;
  logic [AW-1:0] wr_addr    = '0;
  logic [DW-1:0] wr_data    = '0;
  logic          rd_en      = 1'b0;
  logic [AW-1:0] rd_addr    = '0;
  logic          commit_req = 1'b0;
  logic          wr_err, busy, commit_done;
  logic [DW-1:0] rd_data;
  logic [PW-1:0] portselnum [IOW];
  logic [IOW-1:0] out_ena, od;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bidir_io_cfg_ctrl #(.IOWidth(IOW), .PortNumWidth(PW), .GuardCycles(G), .AddrWidth(AW)) dut (
    .clk(clk), .reset(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .commit_req(commit_req), .busy(busy), .commit_done(commit_done),
    .portselnum(portselnum), .out_ena(out_ena), .od(od)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: shadow/active banks plus the cycle T at which the last commit was accepted.
  int            cyc = 0;
  bit            m_run;
  int            m_t;
  logic [IOW-1:0] m_mask;
  logic [PW-1:0] ms_sel [IOW];
  logic [IOW-1:0] ms_ena, ms_od;
  logic [PW-1:0] ma_sel [IOW];
  logic [IOW-1:0] ma_ena, ma_od;
  logic          m_err;
  logic [DW-1:0] m_rd;

  function automatic bit idle_in(input int c);
    return !m_run || (c > m_t + 2 * G + 1);
  endfunction

  function automatic bit exp_busy(input int c);
    return m_run && (c >= m_t + 1) && (c <= m_t + 2 * G + 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run  <= 1'b0;
      m_t    <= 0;
      m_mask <= '0;
      m_err  <= 1'b0;
      m_rd   <= '0;
      ms_ena <= '0; ms_od <= '0; ma_ena <= '0; ma_od <= '0;
      for (int i = 0; i < IOW; i++) begin
        ms_sel[i] <= PW'(i);
        ma_sel[i] <= PW'(i);
      end
    end else begin
      cyc <= cyc + 1;
      if (commit_req && idle_in(cyc)) begin
        m_run <= 1'b1;
        m_t   <= cyc;
        for (int i = 0; i < IOW; i++)
          m_mask[i] <= {ms_od[i], ms_ena[i], ms_sel[i]} != {ma_od[i], ma_ena[i], ma_sel[i]};
      end
      if (m_run && cyc == m_t + G + 1) begin
        ma_sel <= ms_sel;
        ma_ena <= ms_ena;
        ma_od  <= ms_od;
      end
      if (wr_en && idle_in(cyc) && int'(wr_addr) < IOW) begin
        ms_sel[wr_addr] <= wr_data[PW-1:0];
        ms_ena[wr_addr] <= wr_data[PW];
        ms_od[wr_addr]  <= wr_data[PW+1];
      end
      m_err <= wr_en && !(idle_in(cyc) && int'(wr_addr) < IOW);
      if (rd_en) begin
        if (int'(rd_addr) < IOW) m_rd <= {ms_od[rd_addr], ms_ena[rd_addr], ms_sel[rd_addr]};
        else m_rd <= '0;
      end
    end
  end

  int bad;
  always @(negedge clk) begin
    check("busy", busy, exp_busy(cyc));
    check("commit_done", commit_done, m_run && (cyc == m_t + 2 * G + 2));
    check("wr_err", wr_err, m_err);
    check("rd_data", rd_data, m_rd);
    check("out_ena", out_ena, ma_ena & ~(exp_busy(cyc) ? m_mask : '0));
    check("od", od, ma_od);
    bad = 0;
    for (int i = 0; i < IOW; i++) if (portselnum[i] !== ma_sel[i]) bad++;
    check("portselnum_mismatches", bad, 0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input int a, input logic [DW-1:0] exp);
    rd_en = 1'b1; rd_addr = AW'(a);
    step();
    rd_en = 1'b0;
    @(negedge clk);
    check(name, rd_data, exp);
    step();
  endtask

  task automatic commit_watch(input int pin, input logic [PW-1:0] sel, input string tag);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    for (int k = 1; k <= 2 * G + 2; k++) begin
      @(negedge clk);
      check({tag, "_ena"}, out_ena[pin], 1'b1);
      check({tag, "_sel"}, portselnum[pin], sel);
      if (k == 2 * G + 2) check({tag, "_done"}, commit_done, 1'b1);
      step();
    end
  endtask

  int n_done, n_busy;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_ena", out_ena, 36'h0);
    check("rst_sel35", portselnum[35], 8'd35);
    check("rst_busy", busy, 1'b0);
    step();
    rd_chk("rd_pin0", 0, 10'd0);
    rd_chk("rd_pin5", 5, 10'd5);
    rd_chk("rd_pin35", 35, 10'd35);

    // Pin 3 -> sel 7, enabled; commit accepted in cycle T.
    wr(3, 10'h107);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("c1_busy", busy, k <= 5);
      check("c1_ena3", out_ena[3], k == 6);
      check("c1_done", commit_done, k == 6);
      check("c1_sel3", portselnum[3], (k >= 4) ? 8'd7 : 8'd3);
      step();
    end

    wr(4, 10'h309);
    commit_watch(3, 8'd7, "pin3_stable");
    wr(3, 10'h10C);
    commit_watch(4, 8'd9, "pin4_stable");

    // Rejected writes: during busy, and beyond the pin range.
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    wr(10, 10'h3FF);
    @(negedge clk);
    check("err_busy", wr_err, 1'b1);
    step();
    @(negedge clk);
    check("err_clear", wr_err, 1'b0);
    repeat (4) step();
    wr(40, 10'h3FF);
    @(negedge clk);
    check("err_addr40", wr_err, 1'b1);
    step();
    rd_chk("rd_pin10", 10, 10'd10);
    rd_chk("rd_pin40", 40, 10'd0);
    rd_chk("rd_pin3", 3, 10'h10C);

    // commit_req held for 10 cycles: exactly two back-to-back sequences.
    n_done = 0; n_busy = 0;
    commit_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (commit_done) n_done++;
      if (busy) n_busy++;
      step();
      if (k == 9) commit_req = 1'b0;
    end
    check("hold_done_count", n_done, 2);
    check("hold_busy_count", n_busy, 10);

    // Reset in cycle T+3 of a commit.
    wr(6, 10'h114);
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ena", out_ena, 36'h0);
    check("mid_rst_sel6", portselnum[6], 8'd6);
    check("mid_rst_sel3", portselnum[3], 8'd3);
    check("mid_rst_sel4", portselnum[4], 8'd4);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_rst_no_done", commit_done, 1'b0);
      step();
    end
    rd_chk("rd_pin6_after_rst", 6, 10'd6);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
